// File: rtl/pixel_frame_loader.sv
// pixel_frame_loader
//   Collects a raster-order pixel stream into ROWSIZE x COLSIZE frames for the
//   2x2 pooling stage and holds each complete frame until it is accepted.
//
// Ports
//   clk, rst     single rising-edge clock, synchronous active-high reset
//   in_pixel     incoming pixel, row-major, (0,0) first
//   in_valid     in_pixel valid this cycle
//   in_sof       start-of-frame marker, qualified by in_valid
//   in_ready     loader can accept a pixel this cycle
//   frame_out    pixel (r,c) at bits [(COLSIZE*r+c)*WIDTH +: WIDTH]
//   frame_valid  frame_out holds a complete frame
//   frame_ready  downstream accepts the frame
//   sof_err      one-cycle pulse after an in_sof arrived mid-frame
//
// Build option
//   FRAME_LOADER_DBUF_EN  ping-pong double buffering; the next frame fills in
//                         the background while the current one is presented.

module pixel_frame_loader #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ROWSIZE = 5,
  parameter int unsigned COLSIZE = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WIDTH-1:0]                 in_pixel,
  input  logic                             in_valid,
  input  logic                             in_sof,
  output logic                             in_ready,
  output logic [WIDTH*ROWSIZE*COLSIZE-1:0] frame_out,
  output logic                             frame_valid,
  input  logic                             frame_ready,
  output logic                             sof_err
);

  localparam int unsigned N      = ROWSIZE * COLSIZE;
  localparam int unsigned IdxW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned FrameW = WIDTH * N;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  logic [IdxW-1:0] idx_q;
  logic            ready_q;
  logic            valid_q;
  logic            err_q;

  logic            accept;
  logic [IdxW-1:0] slot;
  logic            last;
  logic [IdxW-1:0] next_idx;

  assign accept = in_valid && ready_q;
  // A start-of-frame pixel always lands in slot 0, whatever the index says.
  assign slot   = in_sof ? '0 : idx_q;
  assign last   = (slot == LastIdx);

  always_comb begin
    next_idx = last ? '0 : slot + IdxW'(1);
  end

  assign in_ready    = ready_q;
  assign frame_valid = valid_q;
  assign sof_err     = err_q;

`ifdef FRAME_LOADER_DBUF_EN

  logic [FrameW-1:0] buf_q [2];
  logic              fill_sel_q;
  logic              out_sel_q;
  logic              full_q;     // fill buffer complete, waiting for a swap
  logic              handshake;
  logic              done;

  assign handshake = valid_q && frame_ready;
  assign done      = accept && last;
  assign frame_out = buf_q[out_sel_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      fill_sel_q <= 1'b0;
      out_sel_q  <= 1'b0;
      full_q     <= 1'b0;
      idx_q      <= '0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q   <= 1'b0;
      ready_q <= !full_q;
      if (accept) begin
        buf_q[fill_sel_q][slot*WIDTH +: WIDTH] <= in_pixel;
        idx_q <= next_idx;
        err_q <= in_sof && (idx_q != '0);
      end
      if (done) begin
        if (!valid_q || handshake) begin
          // Nothing left to present: the new frame goes straight out.
          out_sel_q  <= fill_sel_q;
          fill_sel_q <= ~fill_sel_q;
          valid_q    <= 1'b1;
          ready_q    <= 1'b1;
        end else begin
          full_q  <= 1'b1;
          ready_q <= 1'b0;
        end
      end else if (handshake) begin
        if (full_q) begin
          out_sel_q  <= fill_sel_q;
          fill_sel_q <= ~fill_sel_q;
          full_q     <= 1'b0;
          ready_q    <= 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

`else

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e            state_q;
  logic [FrameW-1:0] frame_q;

  assign frame_out = frame_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFill;
      frame_q <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StFill: begin
          ready_q <= 1'b1;
          if (accept) begin
            frame_q[slot*WIDTH +: WIDTH] <= in_pixel;
            idx_q <= next_idx;
            err_q <= in_sof && (idx_q != '0);
            if (last) begin
              state_q <= StHold;
              ready_q <= 1'b0;
              valid_q <= 1'b1;
            end
          end
        end
        StHold: begin
          if (frame_ready) begin
            state_q <= StFill;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

`endif

endmodule
